// File: rtl/life_pkg.sv
// Shared types and default geometry for the Game-of-Life generation scheduler.
package life_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_F0,
      S_F1,
      S_F2,
      S_CAP,
      S_COMMIT,
      S_DONE
   } sched_state_t;

   localparam int unsigned STEP_CYCLES   = 5;
   localparam int unsigned DEF_BLOCK_LEN = 10;
   localparam int unsigned DEF_NBLK      = 10;
   localparam int unsigned DEF_ROWS      = 100;

endpackage

// File: rtl/Evolution.sv
// Combinational Life rule for one block step.
// now_live_o covers cells 0..BLOCK_LEN-2 of the current block.
// prev_live_single_o is the next state of the previous block's last cell.
module Evolution #(
   parameter int unsigned BLOCK_LEN = 10
) (
   input  logic [3*BLOCK_LEN-1:0] line_status_i,
   input  logic [3*BLOCK_LEN-1:0] last_line_status_i,
   output logic [BLOCK_LEN-2:0]   now_live_o,
   output logic                   prev_live_single_o
);

   function automatic logic life_rule(input logic centre, input logic [3:0] cnt);
      return (cnt == 4'd3) || (centre && (cnt == 4'd2));
   endfunction

   // Per row: the previous block's last cell at index 0, then this block's cells.
   logic [BLOCK_LEN:0] win [3];

   // Build the three-row neighbourhood window.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         win[k] = {line_status_i[k*BLOCK_LEN +: BLOCK_LEN],
                   last_line_status_i[k*BLOCK_LEN + BLOCK_LEN - 1]};
      end
   end

   // Next state of cells 0..BLOCK_LEN-2 (their right neighbour lies inside the block).
   always_comb begin
      logic [3:0] cnt;
      cnt        = '0;
      now_live_o = '0;
      for (int i = 0; i < int'(BLOCK_LEN) - 1; i++) begin
         cnt = '0;
         for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
               if (!(k == 1 && j == 1)) begin
                  cnt = cnt + 4'(win[k][i+j]);
               end
            end
         end
         now_live_o[i] = life_rule(win[1][i+1], cnt);
      end
   end

   // Previous block's last cell: its right neighbour is cell 0 of this block.
   always_comb begin
      logic [3:0] cnt;
      cnt = '0;
      for (int k = 0; k < 3; k++) begin
         cnt = cnt + 4'(last_line_status_i[k*BLOCK_LEN + BLOCK_LEN - 2])
                   + 4'(line_status_i[k*BLOCK_LEN]);
         if (k != 1) begin
            cnt = cnt + 4'(last_line_status_i[k*BLOCK_LEN + BLOCK_LEN - 1]);
         end
      end
      prev_live_single_o = life_rule(last_line_status_i[BLOCK_LEN + BLOCK_LEN - 1], cnt);
   end

endmodule

// File: rtl/evolution_scheduler.sv
// Sweeps one Life generation over a ping-pong board RAM, one block step at a time.
module evolution_scheduler
   import life_pkg::*;
#(
   parameter int unsigned BLOCK_LEN = DEF_BLOCK_LEN,
   parameter int unsigned NBLK      = DEF_NBLK,
   parameter int unsigned ROWS      = DEF_ROWS,
   parameter int unsigned IDX_W     = $clog2(ROWS*NBLK)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 halt,
   output logic                 rd_en,
   output logic [IDX_W:0]       rd_addr,
   input  logic [BLOCK_LEN-1:0] rd_data,
   output logic                 wr_en,
   output logic [IDX_W:0]       wr_addr,
   output logic [BLOCK_LEN-1:0] wr_data,
   output logic                 busy,
   output logic                 done,
   output logic                 bank_sel,
   output logic [15:0]          gen_count
);

   localparam int unsigned R_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned B_W = $clog2(NBLK + 1);

   sched_state_t state_q, state_d;
   logic [R_W-1:0] r_q, r_d;
   logic [B_W-1:0] b_q, b_d;
   logic rd_vld_q, rd_vld_d;
   logic [BLOCK_LEN-1:0] row_prev_q, row_prev_d;
   logic [BLOCK_LEN-1:0] row_cur_q, row_cur_d;
   logic [BLOCK_LEN-1:0] row_next_q, row_next_d;
   logic [3*BLOCK_LEN-1:0] last_line_status_q, last_line_status_d;
   logic [BLOCK_LEN-2:0] held_now_q, held_now_d;

   logic                 rd_en_d, wr_en_d, busy_d, done_d, bank_sel_d;
   logic [IDX_W:0]       rd_addr_d, wr_addr_d;
   logic [15:0]          gen_count_d;

   logic [3*BLOCK_LEN-1:0] line_status;
   logic [BLOCK_LEN-2:0]   now_live;
   logic                   prev_live_single;

   assign line_status = {row_next_q, row_cur_q, row_prev_q};
   assign wr_data     = {prev_live_single, held_now_q};

   Evolution #(
      .BLOCK_LEN(BLOCK_LEN)
   ) u_evolution (
      .line_status_i     (line_status),
      .last_line_status_i(last_line_status_q),
      .now_live_o        (now_live),
      .prev_live_single_o(prev_live_single)
   );

   // Next state, counters, captures and the registered strobes for the coming cycle.
   always_comb begin
      int unsigned fetch_row;
      logic        fetch_vld;

      state_d            = state_q;
      r_d                = r_q;
      b_d                = b_q;
      rd_vld_d           = rd_en;
      row_prev_d         = row_prev_q;
      row_cur_d          = row_cur_q;
      row_next_d         = row_next_q;
      last_line_status_d = last_line_status_q;
      held_now_d         = held_now_q;
      bank_sel_d         = bank_sel;
      gen_count_d        = gen_count;
      rd_en_d            = 1'b0;
      rd_addr_d          = '0;
      wr_en_d            = 1'b0;
      wr_addr_d          = '0;
      fetch_row          = 0;
      fetch_vld          = 1'b0;

      if (halt && state_q != S_IDLE && state_q != S_DONE) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d            = S_F0;
                  r_d                = '0;
                  b_d                = '0;
                  last_line_status_d = '0;
               end
            end
            S_F0: state_d = S_F1;
            S_F1: begin
               row_prev_d = rd_vld_q ? rd_data : '0;
               state_d    = S_F2;
            end
            S_F2: begin
               row_cur_d = rd_vld_q ? rd_data : '0;
               state_d   = S_CAP;
            end
            S_CAP: begin
               row_next_d = rd_vld_q ? rd_data : '0;
               state_d    = S_COMMIT;
            end
            S_COMMIT: begin
               held_now_d = now_live;
               if (b_q == B_W'(NBLK)) begin
                  last_line_status_d = '0;
                  b_d                = '0;
                  if (r_q == R_W'(ROWS - 1)) begin
                     state_d = S_DONE;
                  end else begin
                     r_d     = r_q + R_W'(1);
                     state_d = S_F0;
                  end
               end else begin
                  last_line_status_d = line_status;
                  b_d                = b_q + B_W'(1);
                  state_d            = S_F0;
               end
            end
            S_DONE: begin
               state_d     = S_IDLE;
               bank_sel_d  = ~bank_sel;
               gen_count_d = gen_count + 16'd1;
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);

      // Read strobe for the fetch state being entered; out-of-board rows stay dark.
      unique case (state_d)
         S_F0: begin
            fetch_row = 32'(r_d) - 32'd1;
            fetch_vld = (r_d != '0) && (b_d != B_W'(NBLK));
         end
         S_F1: begin
            fetch_row = 32'(r_d);
            fetch_vld = (b_d != B_W'(NBLK));
         end
         S_F2: begin
            fetch_row = 32'(r_d) + 32'd1;
            fetch_vld = (r_d != R_W'(ROWS - 1)) && (b_d != B_W'(NBLK));
         end
         default: begin
            fetch_row = 0;
            fetch_vld = 1'b0;
         end
      endcase
      if (fetch_vld) begin
         rd_en_d   = 1'b1;
         rd_addr_d = {bank_sel, IDX_W'(fetch_row * NBLK + 32'(b_d))};
      end

      // Commit of step b writes the completed block b-1 into the other bank.
      if (state_d == S_COMMIT && b_d != '0) begin
         wr_en_d   = 1'b1;
         wr_addr_d = {~bank_sel, IDX_W'(32'(r_d) * NBLK + 32'(b_d) - 32'd1)};
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q            <= S_IDLE;
         r_q                <= '0;
         b_q                <= '0;
         rd_vld_q           <= 1'b0;
         row_prev_q         <= '0;
         row_cur_q          <= '0;
         row_next_q         <= '0;
         last_line_status_q <= '0;
         held_now_q         <= '0;
         rd_en              <= 1'b0;
         rd_addr            <= '0;
         wr_en              <= 1'b0;
         wr_addr            <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         bank_sel           <= 1'b0;
         gen_count          <= '0;
      end else begin
         state_q            <= state_d;
         r_q                <= r_d;
         b_q                <= b_d;
         rd_vld_q           <= rd_vld_d;
         row_prev_q         <= row_prev_d;
         row_cur_q          <= row_cur_d;
         row_next_q         <= row_next_d;
         last_line_status_q <= last_line_status_d;
         held_now_q         <= held_now_d;
         rd_en              <= rd_en_d;
         rd_addr            <= rd_addr_d;
         wr_en              <= wr_en_d;
         wr_addr            <= wr_addr_d;
         busy               <= busy_d;
         done               <= done_d;
         bank_sel           <= bank_sel_d;
         gen_count          <= gen_count_d;
      end
   end

endmodule

// File: tb/tb_evolution_scheduler.sv
// Directed bench for evolution_scheduler on a 4-row, 2-block, 4-cell board.
module tb_evolution_scheduler;

   localparam int BUSY_CYC = 4 * 3 * 5 + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       halt = 1'b0;
   logic       rd_en, wr_en, busy, done, bank_sel;
   logic [3:0] rd_addr, wr_addr, wr_data;
   logic [3:0] rd_data;
   logic [15:0] gen_count;

   logic [3:0] mem [16];
   logic       ld_en = 1'b0;
   logic [3:0] ld_addr = '0;
   logic [3:0] ld_data = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   evolution_scheduler #(
      .BLOCK_LEN(4),
      .NBLK     (2),
      .ROWS     (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .halt     (halt),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .bank_sel (bank_sel),
      .gen_count(gen_count)
   );

   // Board RAM: registered read, bench preload port has priority over DUT writes.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (wr_en) mem[wr_addr] <= wr_data;
   end

   typedef struct packed {
      logic [7:0][3:0] pre;
      logic [7:0][3:0] exp;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
      end
   endtask

   task automatic load(input logic [3:0] addr, input logic [3:0] data);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = addr;
      ld_data = data;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic load_bank(input logic bank, input logic [7:0][3:0] words);
      for (int w = 0; w < 8; w++) load({bank, 3'(w)}, words[w]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_gen(input int start_at, input int halt_at,
                          output int busy_n, output int wr_n, output int done_n);
      int cyc;
      busy_n = 0;
      wr_n   = 0;
      done_n = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc < 1000) begin
         if (!busy) break;
         busy_n++;
         if (wr_en) wr_n++;
         if (done) done_n++;
         start = (cyc == start_at);
         halt  = (cyc == halt_at);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      halt  = 1'b0;
      check("gen_finished", cyc, 32'(cyc < 1000), 32'd1);
   endtask

   task automatic check_bank(input string nm, input logic bank, input logic [7:0][3:0] words);
      for (int w = 0; w < 8; w++) check(nm, w, 32'(mem[{bank, 3'(w)}]), 32'(words[w]));
   endtask

   initial begin
      int bn, wn, dn, strobes;
      logic [7:0][3:0] zero;
      zero = '0;

      for (int i = 0; i < 5; i++) vecs[i] = '0;
      // cross-block horizontal blinker on row 1
      vecs[0].pre[2] = 4'b1000; vecs[0].pre[3] = 4'b0011;
      vecs[0].exp[1] = 4'b0001; vecs[0].exp[3] = 4'b0001; vecs[0].exp[5] = 4'b0001;
      // vertical blinker against the right edge
      vecs[1].pre[1] = 4'b1000; vecs[1].pre[3] = 4'b1000; vecs[1].pre[5] = 4'b1000;
      vecs[1].exp[3] = 4'b1100;
      // 2x2 block in the top-left corner
      vecs[2].pre[0] = 4'b0011; vecs[2].pre[2] = 4'b0011;
      vecs[2].exp[0] = 4'b0011; vecs[2].exp[2] = 4'b0011;
      // lone cell dies
      vecs[3].pre[4] = 4'b0100;
      // vertical blinker touching the bottom edge, flips across the block seam
      vecs[4].pre[3] = 4'b0001; vecs[4].pre[5] = 4'b0001; vecs[4].pre[7] = 4'b0001;
      vecs[4].exp[4] = 4'b1000; vecs[4].exp[5] = 4'b0011;

      repeat (3) @(negedge clk);
      check("rst_busy", 0, 32'(busy), 32'd0);
      check("rst_strobes", 0, 32'({rd_en, wr_en, done}), 32'd0);
      check("rst_bank_gen", 0, {15'd0, bank_sel, gen_count}, 32'd0);
      rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         do_reset();
         load_bank(1'b0, vecs[v].pre);
         load_bank(1'b1, zero);
         run_gen(0, 0, bn, wn, dn);
         check("busy_cycles", v, 32'(bn), 32'(BUSY_CYC));
         check("writes", v, 32'(wn), 32'd8);
         check("done_pulses", v, 32'(dn), 32'd1);
         check("bank_sel", v, 32'(bank_sel), 32'd1);
         check("gen_count", v, 32'(gen_count), 32'd1);
         check_bank("next_gen", 1'b1, vecs[v].exp);
         check_bank("src_kept", 1'b0, vecs[v].pre);
      end

      // still life ping-pongs back into bank 0
      do_reset();
      load_bank(1'b0, vecs[2].pre);
      load_bank(1'b1, zero);
      run_gen(0, 0, bn, wn, dn);
      load_bank(1'b0, zero);
      run_gen(0, 0, bn, wn, dn);
      check("pp_busy", 0, 32'(bn), 32'(BUSY_CYC));
      check("pp_bank_sel", 0, 32'(bank_sel), 32'd0);
      check("pp_gen_count", 0, 32'(gen_count), 32'd2);
      check_bank("pp_bank0", 1'b0, vecs[2].exp);

      // start while busy is ignored
      do_reset();
      load_bank(1'b0, vecs[0].pre);
      load_bank(1'b1, zero);
      run_gen(10, 0, bn, wn, dn);
      check("restart_busy", 0, 32'(bn), 32'(BUSY_CYC));
      check("restart_writes", 0, 32'(wn), 32'd8);
      check("restart_done", 0, 32'(dn), 32'd1);
      check_bank("restart_out", 1'b1, vecs[0].exp);

      // halt in cycle 20 returns to IDLE in cycle 21 with no side effects
      run_gen(0, 20, bn, wn, dn);
      check("halt_busy", 0, 32'(bn), 32'd20);
      check("halt_done", 0, 32'(dn), 32'd0);
      check("halt_writes", 0, 32'(wn), 32'd2);
      repeat (3) @(negedge clk);
      check("halt_idle", 0, 32'(busy), 32'd0);
      check("halt_bank_sel", 0, 32'(bank_sel), 32'd1);
      check("halt_gen_count", 0, 32'(gen_count), 32'd1);
      // a fresh sweep after the abort is clean
      load_bank(1'b0, zero);
      run_gen(0, 0, bn, wn, dn);
      check("post_halt_gen", 0, 32'(gen_count), 32'd2);
      check_bank("post_halt_out", 1'b0, vecs[0].pre);

      // asynchronous reset mid-sweep
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      check("pre_rst_busy", 0, 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("arst_busy", 0, 32'(busy), 32'd0);
      check("arst_strobes", 0, 32'({rd_en, wr_en, done}), 32'd0);
      check("arst_bank_gen", 0, {15'd0, bank_sel, gen_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      strobes = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rd_en || wr_en || busy || done) strobes++;
      end
      check("arst_quiet", 0, 32'(strobes), 32'd0);

      // generation counter wraps
      do_reset();
      load_bank(1'b0, vecs[3].pre);
      load_bank(1'b1, zero);
      @(negedge clk);
      force dut.gen_count = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.gen_count;
      @(negedge clk);
      check("wrap_preset", 0, 32'(gen_count), 32'h0000FFFF);
      run_gen(0, 0, bn, wn, dn);
      check("wrap_gen_count", 0, 32'(gen_count), 32'd0);
      check("wrap_bank_sel", 0, 32'(bank_sel), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
